// File: rtl/gf_rowseq_ctrl.sv
// GF(2^16) multiplier P = A*B mod G(x) that reuses one MSB-first shift/multiply/reduce row
// over 16 cycles, with valid/ready handshakes on the operand and result sides.
module gf_rowseq_ctrl #(
    parameter int unsigned M = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] b_in,
    input  logic [M-1:0] g_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] p_out,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [M-1:0] a_q, a_d;
    logic [M-1:0] b_q, b_d;
    logic [M-1:0] g_q, g_d;
    logic [M-1:0] p_q, p_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic         accept;
    logic [M-1:0] p_step;

    // HOLD passes out_ready straight through so a new accept can consume the old result.
    assign in_ready = (state_q == StIdle) | ((state_q == StHold) & out_ready);
    assign accept   = in_valid & in_ready;

    // One row: shift, add A when the current B bit is set, fold x^16 back in via G.
    assign p_step = {p_q[M-2:0], 1'b0}
                  ^ (b_q[cnt_q] ? a_q : '0)
                  ^ (p_q[M-1]   ? g_q : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        g_d         = g_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    a_d         = a_in;
                    b_d         = b_in;
                    g_d         = g_in;
                    p_d         = '0;
                    cnt_d       = 4'(M - 1);
                    state_d     = StRun;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else if (state_q == StHold && out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            StRun: begin
                p_d = p_step;
                if (cnt_q == 4'd0) begin
                    state_d     = StHold;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            g_q         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            g_q         <= g_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p_out     = p_q;

endmodule

// File: tb/tb_gf_rowseq_ctrl.sv
// Directed-vector and random-sweep bench for gf_rowseq_ctrl against an MSB-first GF(2^16) model.
module tb_gf_rowseq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] g_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    gf_rowseq_ctrl #(.M(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .g_in      (g_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_out     (p_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic [15:0] exp;
        string       name;
    } vec_t;

    function automatic logic [15:0] gf_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] g);
        logic [15:0] p;
        logic        t;
        p = 16'h0;
        for (int i = 15; i >= 0; i--) begin
            t = p[15];
            p = {p[14:0], 1'b0};
            if (b[i]) p = p ^ a;
            if (t)    p = p ^ g;
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept from IDLE; returns 1ns after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g);
        a_in     = a;
        b_in     = b;
        g_in     = g;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        g_in     = $urandom;
    endtask

    task automatic wait_done(input logic [15:0] exp, input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, 16);
        chk({name, "_p"}, p_out, exp);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    vec_t        vecs[7];
    logic [15:0] held;
    logic        stable;
    int          acc_cyc[3];
    logic [15:0] bb_a[3];
    logic [15:0] bb_b[3];
    logic [15:0] bb_g[3];
    logic [15:0] bb_exp[3];
    int          idx;
    int          cyc;
    logic [15:0] ra, rb, rg;

    initial begin
        vecs[0] = '{16'h0001, 16'h1234, 16'h100B, 16'h1234, "ident"};
        vecs[1] = '{16'h8000, 16'h0002, 16'h100B, 16'h100B, "x16_red"};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h100B, 16'h0000, "a_zero"};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'h100B, 16'h0000, "b_zero"};
        vecs[4] = '{16'h0100, 16'h0100, 16'h100B, 16'h100B, "x8_sq"};
        vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, "g0_ovf"};
        vecs[6] = '{16'h00FF, 16'h0002, 16'h0000, 16'h01FE, "g0_shift"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 16'h0;
        b_in      = 16'h0;
        g_in      = 16'h0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p_out, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].g);
            chk({vecs[i].name, "_busy"}, busy, 1);
            wait_done(vecs[i].exp, vecs[i].name);
            chk({vecs[i].name, "_busy_done"}, busy, 0);
            consume();
            chk({vecs[i].name, "_released"}, out_valid, 0);
        end

        // Backpressure: result and in_ready must hold while out_ready stays low.
        start_op(16'h1234, 16'h5678, 16'h100B);
        wait_done(gf_model(16'h1234, 16'h5678, 16'h100B), "bp");
        held   = p_out;
        stable = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b0;
            if (p_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
            tick();
        end
        chk("bp_stable", stable, 1);
        consume();
        chk("bp_out_valid", out_valid, 0);
        chk("bp_in_ready", in_ready, 1);
        chk("bp_busy", busy, 0);

        // Back-to-back with in_valid and out_ready held high throughout.
        bb_a[0] = 16'h0001; bb_b[0] = 16'hABCD; bb_g[0] = 16'h100B;
        bb_a[1] = 16'h8000; bb_b[1] = 16'h0002; bb_g[1] = 16'h100B;
        bb_a[2] = 16'hC3A5; bb_b[2] = 16'h7E11; bb_g[2] = 16'h002D;
        for (int i = 0; i < 3; i++) bb_exp[i] = gf_model(bb_a[i], bb_b[i], bb_g[i]);
        idx = 0;
        cyc = 0;
        a_in = bb_a[0]; b_in = bb_b[0]; g_in = bb_g[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (idx < 3 && cyc < 200) begin
            if (in_ready) begin
                acc_cyc[idx] = cyc;
                if (idx > 0) begin
                    chk("b2b_valid", out_valid, 1);
                    chk("b2b_p", p_out, bb_exp[idx-1]);
                end
                tick();
                idx++;
                if (idx < 3) begin
                    a_in = bb_a[idx]; b_in = bb_b[idx]; g_in = bb_g[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                tick();
            end
            cyc++;
        end
        chk("b2b_accepts", idx, 3);
        if (idx == 3) begin
            chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 17);
            chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 17);
        end
        out_ready = 1'b0;
        wait_done(bb_exp[2], "b2b_last");
        consume();
        chk("b2b_idle", in_ready, 1);

        // Asynchronous reset in the middle of RUN.
        start_op(16'hBEEF, 16'hCAFE, 16'h100B);
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_p", p_out, 0);
        #2;
        rst_n = 1'b1;
        tick();
        start_op(16'h0003, 16'h0003, 16'h100B);
        wait_done(16'h0005, "post_rst");
        consume();

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rg = (i % 16 == 0) ? 16'h0000 : 16'($urandom);
            start_op(ra, rb, rg);
            wait_done(gf_model(ra, rb, rg), "rand");
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_rowseq_ctrl.md
# gf_rowseq_ctrl

Sequencer that computes P = A·B mod G(x) in GF(2^16) by reusing a single 16-bit MSB-first multiplier row over 16 cycles, instead of a 16-row systolic array. It latches the operands, feeds one multiplier bit per cycle into the row together with the feedback term, and recirculates the partial product. It exposes a valid/ready handshake on both sides, so it can sit between an operand source and a result consumer as the area-reduced alternative to the full array.

## Interface
- M, 16, field degree; only 16 is supported, since the datapath row is 16 bits wide.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set on a_in/b_in/g_in is valid.
- in_ready  out  1  block can accept operands this cycle.
- a_in  in  16  multiplicand A; bit 15 is the x^15 coefficient.
- b_in  in  16  multiplier B; bit 15 is the x^15 coefficient.
- g_in  in  16  reduction polynomial G(x) with the implicit x^16 term removed; bit 0 is the x^0 coefficient.
- out_valid  out  1  p_out holds a finished product.
- out_ready  in  1  consumer accepts p_out this cycle.
- p_out  out  16  product register P.
- busy  out  1  high while in RUN.

## Operation
- States: IDLE, RUN, HOLD. A 4-bit down-counter cnt tracks the current bit of B.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). In HOLD this is a combinational pass-through of out_ready, which allows back-to-back operation.
- Accept occurs when in_valid & in_ready:
  - latch a_in, b_in, g_in into A, B, G;
  - clear P to 0 and set cnt=15;
  - go to RUN.
- Each RUN cycle performs one row step:
  - t = P[15], b = B[cnt];
  - P <= {P[14:0],1'b0} ^ (b ? A : 0) ^ (t ? G : 0).
  - This is exactly the shift, multiply and reduce function of one row: bi = B[cnt], ti = P[15], ai = A, gi = G.
- RUN with cnt==0 performs the last step, then goes to HOLD. Otherwise cnt decrements.
- In HOLD, out_valid=1 and P is held stable.
- Leaving HOLD:
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: accept the new operands in that same cycle and go to RUN. The old result is consumed on that edge.
- In IDLE and RUN, in_valid is ignored except as defined above. Operand inputs are not sampled after the accept edge, so they may change freely.
- In IDLE, out_ready has no effect.
- Arithmetic is carry-less (XOR only). No result bits beyond 16 exist, because the x^16 term is folded in via G every step.
- g_in=0 is legal: the block then computes the plain low-16-bit carry-less product of the MSB-first recurrence. No error is flagged.

## Timing
- Reset values:
  - state=IDLE, cnt=0, A=B=G=0, P=0;
  - in_ready=1, out_valid=0, busy=0, p_out=0x0000.
- Asserting rst_n low at any point, including mid-RUN or in HOLD, returns the block immediately to the reset values. The partial result is lost and no out_valid is produced.
- Latency: accept at edge k, RUN steps at edges k+1..k+16, out_valid=1 after edge k+16. That is 16 cycles from acceptance to result.
- Throughput with continuous in_valid/out_ready: one result per 17 cycles.
- busy=1 exactly for the 16 cycles following an accept edge.
- p_out always shows P. Its value during RUN is a partial product and is meaningful only while out_valid=1.
- out_valid stays high until the cycle in which out_ready=1. It deasserts on the following edge, unless a new accept in that same cycle means the next result is 17 cycles later; out_valid is low during that RUN.

## Test plan
- With g=0x100B (x^16+x^12+x^3+x+1), A=0x0001, B=0x1234: out_valid rises 16 cycles after accept, p_out=0x1234.
- With g=0x100B, A=0x8000, B=0x0002: result x^16 mod G, so p_out=0x100B.
- With A=0x0000 and B=0xFFFF, then A=0xFFFF and B=0x0000: p_out=0x0000 both times. A random A/B/g sweep of at least 1000 operations must match a software MSB-first GF(2^16) reference model.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. p_out stays stable and in_ready stays 0. Raising out_ready for one cycle with in_valid=0 returns the block to IDLE with out_valid=0.
- Back-to-back: keep in_valid=1 and out_ready=1 continuously across 3 operations. Accepts land exactly 17 cycles apart, and each result is correct.
- Pulse rst_n low at RUN cycle 8: all outputs go to reset values asynchronously. A subsequent operation with A=0x0003, B=0x0003, g=0x100B yields p_out=0x0005.
